// File: rtl/branch_resolver_if.sv
// Branch comparator / resolver bundle: branch inputs from the core and comparator,
// resolution, prediction and statistics outputs back to the core.
interface branch_resolver_if;
  logic        br_valid;
  logic [2:0]  funct3;
  logic [31:0] pc;
  logic        br_less;
  logic        br_equal;
  logic        br_unsigned;
  logic        br_taken;
  logic        pred_taken;
  logic        mispredict;
  logic        illegal_br;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output br_valid, funct3, pc, br_less, br_equal,
    input  br_unsigned, br_taken, pred_taken, mispredict, illegal_br,
           branch_count, mispredict_count
  );

  modport slave (
    input  br_valid, funct3, pc, br_less, br_equal,
    output br_unsigned, br_taken, pred_taken, mispredict, illegal_br,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_resolver.sv
// Branch resolution for the single-cycle core: funct3 decode, taken decision,
// 2-bit saturating-counter BHT prediction and branch/mispredict statistics.
module branch_resolver #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned IDX_W       = $clog2(BHT_ENTRIES)
) (
  input logic               i_clk,
  input logic               i_reset,
  branch_resolver_if.slave  br
);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] idx;
  logic [1:0]       ctr;
  logic             illegal;
  logic             legal;
  logic             cond;
  logic             taken;
  logic             pred;
  logic             mis;
  logic [31:0]      branch_cnt;
  logic [31:0]      mispredict_cnt;
  logic             unused_pc;

  assign idx       = br.pc[IDX_W+1:2];
  assign unused_pc = ^br.pc;

  // funct3[0] inverts the base condition: BNE/BGE/BGEU are the complements.
  always_comb begin
    illegal = (br.funct3[2:1] == 2'b01);
    legal   = br.br_valid & ~illegal;
    case (br.funct3[2:1])
      2'b00:        cond = br.br_equal;
      2'b10, 2'b11: cond = br.br_less;
      default:      cond = 1'b0;
    endcase
    taken = legal & (cond ^ br.funct3[0]);
    ctr   = bht[idx];
    pred  = ctr[1];
    mis   = legal & (pred ^ taken);
  end

  assign br.br_unsigned      = br.funct3[1];
  assign br.br_taken         = taken;
  assign br.pred_taken       = pred;
  assign br.mispredict       = mis;
  assign br.illegal_br       = br.br_valid & illegal;
  assign br.branch_count     = branch_cnt;
  assign br.mispredict_count = mispredict_cnt;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int unsigned i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else if (legal) begin
      if (taken && ctr != 2'b11)       bht[idx] <= ctr + 2'd1;
      else if (!taken && ctr != 2'b00) bht[idx] <= ctr - 2'd1;
      branch_cnt <= branch_cnt + 32'd1;
      if (mis) mispredict_cnt <= mispredict_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: per-cycle comparison against a behavioural
// model plus hand-computed expectations for each scenario.
module tb_branch_resolver;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_resolver_if bif ();

  branch_resolver #(.BHT_ENTRIES(64)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .br      (bif.slave)
  );

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  int          m_ctr [64];
  logic [31:0] m_bcnt;
  logic [31:0] m_mcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit f_legal(input logic v, input logic [2:0] f);
    return v && f != 3'd2 && f != 3'd3;
  endfunction

  function automatic bit f_taken(input logic v, input logic [2:0] f, input logic less, input logic eq);
    bit t;
    case (f)
      3'd0: t = eq;       // BEQ
      3'd1: t = !eq;      // BNE
      3'd4: t = less;     // BLT
      3'd5: t = !less;    // BGE
      3'd6: t = less;     // BLTU
      3'd7: t = !less;    // BGEU
      default: t = 1'b0;
    endcase
    return f_legal(v, f) && t;
  endfunction

  function automatic int f_idx(input logic [31:0] p);
    return int'((p / 4) % 64);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) m_ctr[i] = 1;
      m_bcnt = 0;
      m_mcnt = 0;
    end else if (f_legal(bif.br_valid, bif.funct3)) begin
      automatic int  k = f_idx(bif.pc);
      automatic bit  p = m_ctr[k] >= 2;
      automatic bit  t = f_taken(bif.br_valid, bif.funct3, bif.br_less, bif.br_equal);
      if (t) m_ctr[k] = (m_ctr[k] == 3) ? 3 : m_ctr[k] + 1;
      else   m_ctr[k] = (m_ctr[k] == 0) ? 0 : m_ctr[k] - 1;
      m_bcnt = m_bcnt + 32'd1;
      if (p != t) m_mcnt = m_mcnt + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      automatic bit lg = f_legal(bif.br_valid, bif.funct3);
      automatic bit t  = f_taken(bif.br_valid, bif.funct3, bif.br_less, bif.br_equal);
      automatic bit p  = m_ctr[f_idx(bif.pc)] >= 2;
      check("m_unsigned",  32'(bif.br_unsigned), 32'(bif.funct3 == 3'd6 || bif.funct3 == 3'd7 ||
                                                     bif.funct3 == 3'd2 || bif.funct3 == 3'd3));
      check("m_taken",     32'(bif.br_taken),    32'(t));
      check("m_pred",      32'(bif.pred_taken),  32'(p));
      check("m_mispred",   32'(bif.mispredict),  32'(lg && (p != t)));
      check("m_illegal",   32'(bif.illegal_br),  32'(bif.br_valid && !lg));
      check("m_bcount",    bif.branch_count,     m_bcnt);
      check("m_mcount",    bif.mispredict_count, m_mcnt);
    end
  end

  task automatic drive(input logic v, input logic [2:0] f, input logic [31:0] p,
                       input logic less, input logic eq);
    bif.br_valid = v;
    bif.funct3   = f;
    bif.pc       = p;
    bif.br_less  = less;
    bif.br_equal = eq;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [3:0] exp_pred;
    bit [3:0] exp_mis;
    exp_pred = 4'b1110;
    exp_mis  = 4'b0001;
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);
    tick();

    // Reset asserted between edges takes effect at once.
    rst = 1'b1;
    #1;
    check("rst_bcount", bif.branch_count, 32'd0);
    check("rst_mcount", bif.mispredict_count, 32'd0);
    drive(1'b0, 3'd0, 32'h0, 1'b0, 1'b0);  check("rst_pred_0",  32'(bif.pred_taken), 32'd0);
    drive(1'b0, 3'd0, 32'h40, 1'b0, 1'b0); check("rst_pred_40", 32'(bif.pred_taken), 32'd0);
    drive(1'b0, 3'd0, 32'hFC, 1'b0, 1'b0); check("rst_pred_fc", 32'(bif.pred_taken), 32'd0);
    chk_en = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // BEQ saturation at pc 0x100: counter 01 -> 10 -> 11 -> 11.
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 3'd0, 32'h100, 1'b0, 1'b1);
      check("beq_pred",    32'(bif.pred_taken), 32'(exp_pred[k]));
      check("beq_mispred", 32'(bif.mispredict), 32'(exp_mis[k]));
      check("beq_taken",   32'(bif.br_taken),   32'd1);
      tick();
    end
    drive(1'b0, 3'd0, 32'h100, 1'b0, 1'b0);
    check("beq_bcount", bif.branch_count, 32'd4);
    check("beq_mcount", bif.mispredict_count, 32'd1);
    tick();

    // Unsigned select; pc 0x208 uses a fresh entry (01).
    drive(1'b1, 3'd6, 32'h208, 1'b1, 1'b0);
    check("bltu_unsigned", 32'(bif.br_unsigned), 32'd1);
    check("bltu_taken",    32'(bif.br_taken),    32'd1);
    tick();
    drive(1'b1, 3'd7, 32'h208, 1'b1, 1'b0);
    check("bgeu_taken",    32'(bif.br_taken),    32'd0);
    check("bgeu_mispred",  32'(bif.mispredict),  32'd1);
    tick();
    drive(1'b1, 3'd4, 32'h208, 1'b1, 1'b0);
    check("blt_unsigned",  32'(bif.br_unsigned), 32'd0);
    check("blt_taken",     32'(bif.br_taken),    32'd1);
    tick();
    drive(1'b0, 3'd0, 32'h208, 1'b0, 1'b0);
    check("uns_bcount", bif.branch_count, 32'd7);
    check("uns_mcount", bif.mispredict_count, 32'd4);

    // Illegal funct3 on a strongly-taken entry: no effect on any state.
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 3'd3, 32'h100, 1'b1, 1'b1);
      check("ill_flag",    32'(bif.illegal_br), 32'd1);
      check("ill_taken",   32'(bif.br_taken),   32'd0);
      check("ill_mispred", 32'(bif.mispredict), 32'd0);
      check("ill_pred",    32'(bif.pred_taken), 32'd1);
      tick();
    end
    drive(1'b0, 3'd0, 32'h100, 1'b0, 1'b0);
    check("ill_bcount", bif.branch_count, 32'd7);
    check("ill_mcount", bif.mispredict_count, 32'd4);
    check("ill_pred_after", 32'(bif.pred_taken), 32'd1);

    // Aliasing: 0x004 and 0x104 share index 1.
    drive(1'b1, 3'd0, 32'h004, 1'b0, 1'b1); tick();
    drive(1'b1, 3'd0, 32'h004, 1'b0, 1'b1); tick();
    drive(1'b0, 3'd0, 32'h004, 1'b0, 1'b0);
    check("alias_pred_11", 32'(bif.pred_taken), 32'd1);
    drive(1'b1, 3'd1, 32'h104, 1'b0, 1'b1);
    check("alias_mis_1", 32'(bif.mispredict), 32'd1);
    tick();
    drive(1'b0, 3'd0, 32'h004, 1'b0, 1'b0);
    check("alias_pred_10", 32'(bif.pred_taken), 32'd1);
    drive(1'b1, 3'd1, 32'h104, 1'b0, 1'b1); tick();
    drive(1'b0, 3'd0, 32'h004, 1'b0, 1'b0);
    check("alias_pred_01", 32'(bif.pred_taken), 32'd0);
    check("alias_bcount", bif.branch_count, 32'd11);
    check("alias_mcount", bif.mispredict_count, 32'd7);
    tick();

    // Statistics wrap.
    force dut.branch_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt;
    m_bcnt = 32'hFFFF_FFFF;
    check("wrap_pre", bif.branch_count, 32'hFFFF_FFFF);
    drive(1'b1, 3'd5, 32'h300, 1'b0, 1'b0);
    tick();
    drive(1'b0, 3'd0, 32'h300, 1'b0, 1'b0);
    check("wrap_bcount", bif.branch_count, 32'd0);
    tick();

    // Reset pulsed during a valid branch cycle discards the update.
    drive(1'b1, 3'd0, 32'h30C, 1'b0, 1'b1);
    rst = 1'b1;
    #1;
    check("rr_bcount", bif.branch_count, 32'd0);
    check("rr_mcount", bif.mispredict_count, 32'd0);
    check("rr_pred",   32'(bif.pred_taken), 32'd0);
    check("rr_mispred", 32'(bif.mispredict), 32'd1);
    tick();
    drive(1'b0, 3'd0, 32'h30C, 1'b0, 1'b0);
    rst = 1'b0;
    #1;
    check("rr_pred_after", 32'(bif.pred_taken), 32'd0);
    check("rr_bcount_after", bif.branch_count, 32'd0);
    check("rr_mcount_after", bif.mispredict_count, 32'd0);
    tick();

    // First edge after release updates normally.
    drive(1'b1, 3'd0, 32'h30C, 1'b0, 1'b1);
    tick();
    drive(1'b0, 3'd0, 32'h30C, 1'b0, 1'b0);
    check("post_pred", 32'(bif.pred_taken), 32'd1);
    check("post_bcount", bif.branch_count, 32'd1);
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
